ir_loader: RTL and testbench

//   Instruction-memory stage directly upstream of ir_decoder. Accepts a program

---
 rtl/ir_loader_pkg.sv | 22 ++
 rtl/ir_ram.sv | 26 ++
 rtl/ir_loader.sv | 122 ++++++++++++
 tb/tb_ir_loader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ir_loader_pkg.sv
// Shared constants and state types for the IR loader and its RAM.
// Pure declarations; no timing or flow control of its own.
package ir_loader_pkg;

  localparam int              IR_DATA_WIDTH = 8;
  localparam int              IR_ADDR_WIDTH = 8;
  localparam logic [7:0]      IR_STOP_OP    = 8'b0000_1110;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

  // Where the ir output currently comes from; lets ir hold without an extra data flop.
  typedef enum logic [1:0] {
    IR_SRC_ZERO = 2'd0,
    IR_SRC_STOP = 2'd1,
    IR_SRC_RAM  = 2'd2
  } ir_src_t;

endpackage

// File: rtl/ir_ram.sv
// 1W/1R program RAM, registered read data one cycle after re; read data holds when re is low.
// No backpressure: a write or read is performed whenever its enable is high.
module ir_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ir_loader.sv
// Loads a program byte stream into IR RAM, then serves irp fetches with 1-cycle latency.
// load_ready is high only while loading and no restart is pending; fetches never stall.
module ir_loader
  import ir_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = IR_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = IR_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] STOP_OP    = DATA_WIDTH'(IR_STOP_OP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_finished,
  output logic [ADDR_WIDTH:0]   ir_count,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  ir_valid,
  output logic [DATA_WIDTH-1:0] ir
);

  ld_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  fin_q, fin_d;
  logic                  ir_valid_q, ir_valid_d;
  ir_src_t               ir_src_q, ir_src_d;
  logic                  accept;
  logic                  fetch_ok;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign load_ready = (state_q == LD_LOAD) && !load_start;
  assign accept     = load_valid && load_ready;
  // A restart in DONE takes priority over a same-cycle fetch.
  assign fetch_ok   = (state_q == LD_DONE) && fetch_req && !load_start;
  assign in_range   = {1'b0, fetch_addr} < count_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fin_d      = fin_q;
    ir_valid_d = 1'b0;
    ir_src_d   = ir_src_q;

    if (load_start) begin
      state_d  = LD_LOAD;
      wr_ptr_d = '0;
      count_d  = '0;
      fin_d    = 1'b0;
    end else begin
      case (state_q)
        LD_LOAD: begin
          if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            if (load_last || (wr_ptr_q == '1)) begin
              state_d = LD_DONE;
              fin_d   = 1'b1;
            end
          end
        end
        LD_IDLE, LD_DONE: ;
        default: state_d = LD_IDLE;
      endcase
    end

    if (fetch_ok) begin
      ir_valid_d = 1'b1;
      ir_src_d   = in_range ? IR_SRC_RAM : IR_SRC_STOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fin_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_src_q   <= IR_SRC_ZERO;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fin_q      <= fin_d;
      ir_valid_q <= ir_valid_d;
      ir_src_q   <= ir_src_d;
    end
  end

  ir_ram #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (load_data),
    .re    (fetch_ok),
    .raddr (fetch_addr),
    .rdata (ram_rdata)
  );

  always_comb begin
    ir = '0;
    case (ir_src_q)
      IR_SRC_RAM:  ir = ram_rdata;
      IR_SRC_STOP: ir = STOP_OP;
      default:     ir = '0;
    endcase
  end

  assign load_finished = fin_q;
  assign ir_count      = count_q;
  assign ir_valid      = ir_valid_q;

endmodule

// File: tb/tb_ir_loader.sv
// Bench for ir_loader: directed phases with random data, checked against a program-image model.
module tb_ir_loader;

  localparam logic [7:0] STOP = 8'h0E;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start, load_valid, load_last, fetch_req;
  logic [7:0] load_data, fetch_addr;
  logic       load_ready, load_finished, ir_valid;
  logic [8:0] ir_count;
  logic [7:0] ir;

  always #5 clk = ~clk;

  ir_loader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .STOP_OP   (8'h0E)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .load_finished(load_finished),
    .ir_count     (ir_count),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .ir_valid     (ir_valid),
    .ir           (ir)
  );

  int compared   = 0;
  int mismatched = 0;

  // Program image: bytes appended in order; mode 0 = no program, 1 = loading, 2 = resident.
  logic [7:0] m_mem [256];
  int         m_count = 0;
  int         m_mode  = 0;
  bit         m_fin   = 1'b0;
  logic [7:0] e_ir    = 8'h00;
  bit         e_irv   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string phase);
    chk({phase, ":ir_valid"}, 32'(ir_valid), 32'(e_irv));
    chk({phase, ":ir"}, 32'(ir), 32'(e_ir));
    chk({phase, ":load_finished"}, 32'(load_finished), 32'(m_fin));
    chk({phase, ":ir_count"}, 32'(ir_count), 32'(m_count));
  endtask

  // One clock cycle: drive inputs, check load_ready, advance model, check registered outputs.
  task automatic cyc(input string phase, input bit ls, input bit lv, input logic [7:0] ld,
                     input bit ll, input bit fr, input logic [7:0] fa);
    bit rdy;
    load_start = ls; load_valid = lv; load_data = ld; load_last = ll;
    fetch_req  = fr; fetch_addr = fa;
    #1;
    rdy = (m_mode == 1) && !ls;
    chk({phase, ":load_ready"}, 32'(load_ready), 32'(rdy));
    if (m_mode == 2 && fr && !ls) begin
      e_irv = 1'b1;
      e_ir  = (int'(fa) < m_count) ? m_mem[fa] : STOP;
    end else begin
      e_irv = 1'b0;
    end
    if (ls) begin
      m_mode = 1; m_count = 0; m_fin = 1'b0;
    end else if (lv && rdy) begin
      m_mem[m_count] = ld;
      m_count++;
      if (ll || m_count == 256) begin
        m_mode = 2; m_fin = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_outputs(phase);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes [$];
    int n, i;
    bit v;

    rst = 1'b1;
    load_start = 0; load_valid = 0; load_data = 0; load_last = 0; fetch_req = 0; fetch_addr = 0;
    #1;
    chk("reset:load_ready", 32'(load_ready), 32'd0);
    check_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Valid without a start is never accepted.
    for (int k = 0; k < 3; k++) cyc("nostart", 0, 1, 8'(k), 0, 1, 8'(k));

    // Full load 0x00..0xFF without gaps; DONE entered via the depth boundary.
    cyc("full", 1, 0, 8'h00, 0, 0, 8'h00);
    for (int k = 0; k < 256; k++) cyc("full", 0, 1, 8'(k), 0, 0, 8'h00);
    cyc("full_fetch5", 0, 0, 8'h00, 0, 1, 8'h05);
    cyc("full_hold", 0, 0, 8'h00, 0, 0, 8'h00);
    for (int k = 0; k < 20; k++) cyc("full_rand", 0, 0, 8'h00, 0, 1, 8'($urandom));

    // Short program with load_last on the third byte.
    cyc("short", 1, 0, 8'h00, 0, 0, 8'h00);
    cyc("short", 0, 1, 8'h80, 0, 0, 8'h00);
    cyc("short", 0, 1, 8'h12, 0, 0, 8'h00);
    cyc("short", 0, 1, 8'h0E, 1, 0, 8'h00);
    cyc("short_fetch1", 0, 0, 8'h00, 0, 1, 8'h01);
    cyc("short_fetch3", 0, 0, 8'h00, 0, 1, 8'h03);
    cyc("short_fetch0", 0, 0, 8'h00, 0, 1, 8'h00);
    cyc("short_fetchff", 0, 0, 8'h00, 0, 1, 8'hFF);

    // Random program with ~50% valid duty and fetch requests sprinkled in during load.
    n = $urandom_range(5, 40);
    bytes = {};
    for (int k = 0; k < n; k++) bytes.push_back(8'($urandom));
    cyc("rand", 1, 0, 8'h00, 0, 0, 8'h00);
    i = 0;
    while (i < n) begin
      v = 1'($urandom_range(0, 1));
      cyc("rand_load", 0, v, bytes[i], i == n - 1, 1'($urandom_range(0, 1)), 8'($urandom));
      if (v) i++;
    end
    for (int a = 0; a < n + 4; a++) cyc("rand_read", 0, 0, 8'h00, 0, 1, 8'(a));

    // Restart in DONE with a simultaneous fetch, then a restart in LOAD with a held byte.
    cyc("restart_done", 1, 0, 8'h00, 0, 1, 8'h03);
    cyc("reload", 0, 1, 8'hA5, 0, 0, 8'h00);
    cyc("restart_load", 1, 1, 8'h3C, 0, 0, 8'h00);
    cyc("reload", 0, 1, 8'h3C, 0, 0, 8'h00);
    cyc("reload", 0, 1, 8'hC3, 1, 0, 8'h00);
    for (int a = 0; a < 3; a++) cyc("reload_read", 0, 0, 8'h00, 0, 1, 8'(a));

    // Asynchronous reset after ten accepts.
    cyc("prerst", 1, 0, 8'h00, 0, 0, 8'h00);
    for (int k = 0; k < 10; k++) cyc("prerst", 0, 1, 8'($urandom), 0, 0, 8'h00);
    load_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    m_mode = 0; m_count = 0; m_fin = 1'b0; e_ir = 8'h00; e_irv = 1'b0;
    chk("async_rst:load_ready", 32'(load_ready), 32'd0);
    check_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc("postrst", 0, 1, 8'hEE, 0, 1, 8'h00);
    cyc("postrst_load", 1, 0, 8'h00, 0, 0, 8'h00);
    cyc("postrst_load", 0, 1, 8'h5A, 1, 0, 8'h00);
    cyc("postrst_read0", 0, 0, 8'h00, 0, 1, 8'h00);
    cyc("postrst_read1", 0, 0, 8'h00, 0, 1, 8'h01);
    cyc("postrst_idle", 0, 0, 8'h00, 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
